// File: rtl/writeback_stage.sv
// RV32I writeback stage: selects ALU / load / PC+4 result and drives the register-file write port.
// Loads stall the stage in WAIT_MEM until data arrives or the timeout abandons them.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new instruction; non-loads retire the next cycle
// WAIT_MEM | load accepted, waiting for memrvalid_i or timeout
module writeback_stage #(
    parameter int DWIDTH   = 32,
    parameter int TIMEOUT  = 16,
    parameter int CNTWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [DWIDTH-1:0]   pc_i,
    input  logic [DWIDTH-1:0]   alu_res_i,
    input  logic [4:0]          rd_i,
    input  logic                regwren_i,
    input  logic [1:0]          wbsel_i,
    input  logic [2:0]          funct3_i,
    input  logic [DWIDTH-1:0]   memrdata_i,
    input  logic                memrvalid_i,
    output logic [4:0]          rf_rd_o,
    output logic [DWIDTH-1:0]   rf_data_o,
    output logic                rf_wren_o,
    output logic [CNTWIDTH-1:0] retired_o,
    output logic                err_o
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT_MEM} state_t;

    state_t              r_state, w_state_nxt;
    logic                w_ready, w_accept, w_load_done, w_timeout;
    logic [TW-1:0]       r_tcnt;
    logic [4:0]          r_ld_rd;
    logic [2:0]          r_ld_funct3;
    logic [1:0]          r_ld_addr;
    logic                r_ld_wren;
    logic [4:0]          r_rf_rd;
    logic [DWIDTH-1:0]   r_rf_data;
    logic                r_rf_wren;
    logic [CNTWIDTH-1:0] r_retired;
    logic                r_err;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DWIDTH-1:0]   w_load_data, w_exec_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_load_done = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (valid_i) begin
                    w_accept = 1'b1;
                    if (wbsel_i == 2'd1) w_state_nxt = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                // Data arriving on the final allowed cycle still wins over the timeout.
                if (memrvalid_i) begin
                    w_load_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_ld_addr)
            2'd0:    w_byte = memrdata_i[7:0];
            2'd1:    w_byte = memrdata_i[15:8];
            2'd2:    w_byte = memrdata_i[23:16];
            default: w_byte = memrdata_i[31:24];
        endcase
        w_half = r_ld_addr[1] ? memrdata_i[31:16] : memrdata_i[15:0];
        case (r_ld_funct3)
            3'b000:  w_load_data = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {{(DWIDTH-8){1'b0}}, w_byte};
            3'b001:  w_load_data = {{(DWIDTH-16){w_half[15]}}, w_half};
            3'b101:  w_load_data = {{(DWIDTH-16){1'b0}}, w_half};
            default: w_load_data = memrdata_i;
        endcase
        w_exec_data = (wbsel_i == 2'd2) ? (pc_i + DWIDTH'(4)) : alu_res_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt      <= '0;
            r_ld_rd     <= '0;
            r_ld_funct3 <= '0;
            r_ld_addr   <= '0;
            r_ld_wren   <= 1'b0;
            r_rf_rd     <= '0;
            r_rf_data   <= '0;
            r_rf_wren   <= 1'b0;
            r_retired   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rf_wren <= 1'b0;
            if (w_accept) begin
                if (wbsel_i == 2'd1) begin
                    r_ld_rd     <= rd_i;
                    r_ld_funct3 <= funct3_i;
                    r_ld_addr   <= alu_res_i[1:0];
                    r_ld_wren   <= regwren_i;
                    r_tcnt      <= '0;
                end else begin
                    r_rf_rd   <= rd_i;
                    r_rf_data <= w_exec_data;
                    r_rf_wren <= regwren_i && (rd_i != 5'd0);
                    r_retired <= r_retired + CNTWIDTH'(1);
                end
            end
            if (w_load_done) begin
                r_rf_rd   <= r_ld_rd;
                r_rf_data <= w_load_data;
                r_rf_wren <= r_ld_wren && (r_ld_rd != 5'd0);
                r_retired <= r_retired + CNTWIDTH'(1);
            end
            // An abandoned load still counts as retired but never writes.
            if (w_timeout) begin
                r_err     <= 1'b1;
                r_retired <= r_retired + CNTWIDTH'(1);
            end else if (r_state == S_WAIT_MEM && !memrvalid_i) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign ready_o   = w_ready;
    assign rf_rd_o   = r_rf_rd;
    assign rf_data_o = r_rf_data;
    assign rf_wren_o = r_rf_wren;
    assign retired_o = r_retired;
    assign err_o     = r_err;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/JAL/load extraction, load latency, timeout,
// back-to-back flow and reset during a pending load.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, regwren_i, memrvalid_i, rf_wren_o, err_o;
    logic [31:0] pc_i, alu_res_i, memrdata_i, rf_data_o, retired_o;
    logic [4:0]  rd_i, rf_rd_o;
    logic [1:0]  wbsel_i;
    logic [2:0]  funct3_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_ret = 0;

    writeback_stage #(.DWIDTH(32), .TIMEOUT(16), .CNTWIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
        .alu_res_i(alu_res_i), .rd_i(rd_i), .regwren_i(regwren_i), .wbsel_i(wbsel_i),
        .funct3_i(funct3_i), .memrdata_i(memrdata_i), .memrvalid_i(memrvalid_i),
        .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o), .rf_wren_o(rf_wren_o),
        .retired_o(retired_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] pc, input logic [2:0] f3, input logic wr);
        wbsel_i = sel; rd_i = rd; alu_res_i = alu; pc_i = pc; funct3_i = f3; regwren_i = wr;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [2:0] f3, input logic wr);
        set_fields(sel, rd, alu, pc, f3, wr);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input int k, input logic [31:0] mdata,
                           input logic [31:0] exp_data);
        int low = 0;
        issue(2'd1, rd, addr, 32'h0, f3, 1'b1);
        for (int i = 1; i < k; i++) begin
            if (!ready_o) low++;
            step();
        end
        if (!ready_o) low++;
        memrvalid_i = 1'b1;
        memrdata_i  = mdata;
        step();
        memrvalid_i = 1'b0;
        memrdata_i  = 32'h0;
        exp_ret++;
        check_val({tag, "_ready_low"}, low, k);
        check_val({tag, "_ready"}, ready_o, 1'b1);
        check_val({tag, "_data"}, rf_data_o, exp_data);
        check_val({tag, "_wren"}, rf_wren_o, 1'b1);
        check_val({tag, "_rd"}, rf_rd_o, rd);
        check_val({tag, "_ret"}, retired_o, exp_ret);
    endtask

    initial begin
        int  low;
        logic saw_wren;
        rst = 1'b1; valid_i = 1'b0; memrvalid_i = 1'b0; memrdata_i = 32'h0;
        set_fields(2'd0, 5'd0, 32'h0, 32'h0, 3'd0, 1'b0);
        step(); step();
        check_val("rst_ready", ready_o, 1'b1);
        check_val("rst_wren", rf_wren_o, 1'b0);
        check_val("rst_rd", rf_rd_o, 5'd0);
        check_val("rst_data", rf_data_o, 32'h0);
        check_val("rst_ret", retired_o, 32'h0);
        check_val("rst_err", err_o, 1'b0);
        rst = 1'b0;
        step();

        issue(2'd0, 5'd5, 32'h0000_1234, 32'h0, 3'd0, 1'b1);
        exp_ret++;
        check_val("addi_wren", rf_wren_o, 1'b1);
        check_val("addi_rd", rf_rd_o, 5'd5);
        check_val("addi_data", rf_data_o, 32'h0000_1234);
        check_val("addi_ret", retired_o, exp_ret);
        step();
        check_val("addi_pulse", rf_wren_o, 1'b0);

        issue(2'd2, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0, 1'b1);
        exp_ret++;
        check_val("jal_data", rf_data_o, 32'h0000_0000);
        check_val("jal_wren", rf_wren_o, 1'b1);
        check_val("jal_rd", rf_rd_o, 5'd1);
        issue(2'd2, 5'd0, 32'h0, 32'h0000_1000, 3'd0, 1'b1);
        exp_ret++;
        check_val("jal0_wren", rf_wren_o, 1'b0);
        check_val("jal0_data", rf_data_o, 32'h0000_1004);
        check_val("jal0_ret", retired_o, exp_ret);
        issue(2'd3, 5'd7, 32'hDEAD_BEEF, 32'h0, 3'd0, 1'b1);
        exp_ret++;
        check_val("sel3_data", rf_data_o, 32'hDEAD_BEEF);
        issue(2'd0, 5'd8, 32'h5, 32'h0, 3'd0, 1'b0);
        exp_ret++;
        check_val("nowr_wren", rf_wren_o, 1'b0);
        check_val("nowr_ret", retired_o, exp_ret);

        memrvalid_i = 1'b1; memrdata_i = 32'h1111_1111;
        step();
        memrvalid_i = 1'b0;
        check_val("idle_mv_wren", rf_wren_o, 1'b0);
        check_val("idle_mv_ret", retired_o, exp_ret);

        do_load("lb",  3'b000, 32'h0000_1003, 5'd10, 3, 32'h80FF_FF7F, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_1003, 5'd11, 3, 32'h80FF_FF7F, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_1002, 5'd12, 3, 32'h80FF_FF7F, 32'hFFFF_80FF);
        do_load("lhu", 3'b101, 32'h0000_1000, 5'd13, 3, 32'h80FF_FF7F, 32'h0000_FF7F);
        do_load("lh3", 3'b001, 32'h0000_1003, 5'd14, 1, 32'h80FF_FF7F, 32'hFFFF_80FF);
        do_load("lb1", 3'b000, 32'h0000_1001, 5'd15, 2, 32'h80FF_FF7F, 32'hFFFF_FFFF);
        do_load("lw",  3'b010, 32'h0000_1000, 5'd16, 1, 32'h80FF_FF7F, 32'h80FF_FF7F);
        do_load("lw16", 3'b010, 32'h0000_2000, 5'd17, 16, 32'h0BAD_F00D, 32'h0BAD_F00D);
        check_val("lw16_err", err_o, 1'b0);

        issue(2'd1, 5'd18, 32'h0000_3000, 32'h0, 3'b010, 1'b1);
        low = 0; saw_wren = 1'b0;
        for (int i = 0; i < 40 && !ready_o; i++) begin
            low++;
            saw_wren |= rf_wren_o;
            step();
        end
        exp_ret++;
        check_val("to_wait_cycles", low, 16);
        check_val("to_err", err_o, 1'b1);
        check_val("to_no_write", {saw_wren, rf_wren_o}, 2'b00);
        check_val("to_ready", ready_o, 1'b1);
        check_val("to_ret", retired_o, exp_ret);

        set_fields(2'd0, 5'd3, 32'h0000_0011, 32'h0, 3'd0, 1'b1);
        valid_i = 1'b1;
        step();
        check_val("b2b_add1_data", rf_data_o, 32'h0000_0011);
        check_val("b2b_add1_wren", rf_wren_o, 1'b1);
        set_fields(2'd1, 5'd4, 32'h0000_0100, 32'h0, 3'b010, 1'b1);
        step();
        check_val("b2b_ld_ready", ready_o, 1'b0);
        check_val("b2b_ld_wren", rf_wren_o, 1'b0);
        set_fields(2'd0, 5'd6, 32'h0000_0022, 32'h0, 3'd0, 1'b1);
        memrvalid_i = 1'b1; memrdata_i = 32'hCAFE_BABE;
        step();
        memrvalid_i = 1'b0; memrdata_i = 32'h0;
        check_val("b2b_ld_data", rf_data_o, 32'hCAFE_BABE);
        check_val("b2b_ld_rd", rf_rd_o, 5'd4);
        check_val("b2b_ld_wr", rf_wren_o, 1'b1);
        step();
        valid_i = 1'b0;
        check_val("b2b_add2_data", rf_data_o, 32'h0000_0022);
        check_val("b2b_add2_rd", rf_rd_o, 5'd6);
        check_val("b2b_add2_wren", rf_wren_o, 1'b1);
        step();
        exp_ret += 3;
        check_val("b2b_nodup", rf_wren_o, 1'b0);
        check_val("b2b_ret", retired_o, exp_ret);

        issue(2'd1, 5'd9, 32'h0000_0000, 32'h0, 3'b010, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mrst_ready", ready_o, 1'b1);
        memrvalid_i = 1'b1; memrdata_i = 32'h1234_5678;
        step();
        memrvalid_i = 1'b0;
        check_val("mrst_wren", rf_wren_o, 1'b0);
        check_val("mrst_ret", retired_o, 32'h0);
        check_val("mrst_err", err_o, 1'b0);
        check_val("mrst_data", rf_data_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
